// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: dispatch, rename, writeback,
// operand query, in-order commit and flush redirect.
interface reorder_buffer_if #(
  parameter int NICK_W = 5,
  parameter int DATA_W = 32
);
  logic              iDP_en;
  logic [4:0]        iDP_rd_regnm;
  logic [DATA_W-1:0] iDP_pc;
  logic              iDP_br;
  logic              iDP_pd;
  logic              iDP_st;
  logic              oDP_full;
  logic [NICK_W-1:0] oDP_nick;
  logic              oREG_nick_en;
  logic [4:0]        oREG_nick_regnm;
  logic [NICK_W-1:0] oREG_nick;
  logic              iCDB_en;
  logic [NICK_W-1:0] iCDB_nick;
  logic [DATA_W-1:0] iCDB_dt;
  logic              iCDB_jump;
  logic [DATA_W-1:0] iCDB_tgt;
  logic              iLSB_en;
  logic [NICK_W-1:0] iLSB_nick;
  logic [DATA_W-1:0] iLSB_dt;
  logic [NICK_W-1:0] iQ1_nick;
  logic [NICK_W-1:0] iQ2_nick;
  logic              oQ1_rdy;
  logic              oQ2_rdy;
  logic [DATA_W-1:0] oQ1_dt;
  logic [DATA_W-1:0] oQ2_dt;
  logic              oREG_en;
  logic [4:0]        oREG_rd_regnm;
  logic [DATA_W-1:0] oREG_rd_dt;
  logic [NICK_W-1:0] oREG_rd_nick;
  logic              oLSB_commit_en;
  logic [NICK_W-1:0] oLSB_commit_nick;
  logic              oclr;
  logic [DATA_W-1:0] oIF_pc;

  modport master (
    output iDP_en, iDP_rd_regnm, iDP_pc,
    output iDP_br, iDP_pd, iDP_st,
    input  oDP_full, oDP_nick,
    input  oREG_nick_en, oREG_nick_regnm,
    input  oREG_nick,
    output iCDB_en, iCDB_nick, iCDB_dt,
    output iCDB_jump, iCDB_tgt,
    output iLSB_en, iLSB_nick, iLSB_dt,
    output iQ1_nick, iQ2_nick,
    input  oQ1_rdy, oQ2_rdy, oQ1_dt, oQ2_dt,
    input  oREG_en, oREG_rd_regnm,
    input  oREG_rd_dt, oREG_rd_nick,
    input  oLSB_commit_en, oLSB_commit_nick,
    input  oclr, oIF_pc
  );

  modport slave (
    input  iDP_en, iDP_rd_regnm, iDP_pc,
    input  iDP_br, iDP_pd, iDP_st,
    output oDP_full, oDP_nick,
    output oREG_nick_en, oREG_nick_regnm,
    output oREG_nick,
    input  iCDB_en, iCDB_nick, iCDB_dt,
    input  iCDB_jump, iCDB_tgt,
    input  iLSB_en, iLSB_nick, iLSB_dt,
    input  iQ1_nick, iQ2_nick,
    output oQ1_rdy, oQ2_rdy, oQ1_dt, oQ2_dt,
    output oREG_en, oREG_rd_regnm,
    output oREG_rd_dt, oREG_rd_nick,
    output oLSB_commit_en, oLSB_commit_nick,
    output oclr, oIF_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, collects
// CDB/LSB results, commits in order and flushes on mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int NICK_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  reorder_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [NICK_W-1:0] MAX_NICK = NICK_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ROB_SIZE);

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              br;
    logic              pd;
    logic              st;
    logic              jump;
    logic [4:0]        rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] dt;
    logic [DATA_W-1:0] tgt;
  } ent_t;

  ent_t rob [ROB_SIZE];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic              reg_en;
  logic [4:0]        reg_rd;
  logic [DATA_W-1:0] reg_dt;
  logic [NICK_W-1:0] reg_nick;
  logic              lsb_en;
  logic [NICK_W-1:0] lsb_nick;
  logic              clr;
  logic [DATA_W-1:0] if_pc;

  function automatic logic in_rng(
    input logic [NICK_W-1:0] n
  );
    return (n != '0) && (n <= MAX_NICK);
  endfunction

  function automatic logic [IDX_W-1:0] slot(
    input logic [NICK_W-1:0] n
  );
    return IDX_W'(n - NICK_W'(1));
  endfunction

  logic [IDX_W-1:0]  cdb_idx;
  logic [IDX_W-1:0]  lsb_idx;
  logic              cdb_wr;
  logic              lsb_wr;
  logic              full;
  logic              alloc;
  logic              cm;
  logic              mis;
  ent_t              head_e;
  ent_t              new_e;
  logic [NICK_W-1:0] head_nick;
  logic [NICK_W-1:0] tail_nick;
  logic [DATA_W-1:0] redirect;

  assign cdb_idx = slot(bus.iCDB_nick);
  assign lsb_idx = slot(bus.iLSB_nick);
  assign cdb_wr  = bus.iCDB_en && in_rng(bus.iCDB_nick)
                && rob[cdb_idx].valid;
  assign lsb_wr  = bus.iLSB_en && in_rng(bus.iLSB_nick)
                && rob[lsb_idx].valid;

  assign full      = (count == FULL_CNT);
  assign head_e    = rob[head];
  assign head_nick = NICK_W'(head) + NICK_W'(1);
  assign tail_nick = NICK_W'(tail) + NICK_W'(1);
  assign alloc     = rdy && !rst && bus.iDP_en && !full;
  assign cm        = rdy && !rst && head_e.valid
                  && head_e.ready;
  assign mis       = cm && head_e.br
                  && (head_e.jump != head_e.pd);
  assign redirect  = head_e.jump ? head_e.tgt
                   : head_e.pc + DATA_W'(4);

  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.br    = bus.iDP_br;
    new_e.pd    = bus.iDP_pd;
    new_e.st    = bus.iDP_st;
    new_e.rd    = bus.iDP_rd_regnm;
    new_e.pc    = bus.iDP_pc;
  end

  assign bus.oDP_full        = full;
  assign bus.oDP_nick        = tail_nick;
  assign bus.oREG_nick_en    = alloc
                            && (bus.iDP_rd_regnm != 5'd0);
  assign bus.oREG_nick_regnm = bus.iDP_rd_regnm;
  assign bus.oREG_nick       = tail_nick;

  logic [NICK_W-1:0] q_nick [2];
  logic              q_rdy  [2];
  logic [DATA_W-1:0] q_dt   [2];

  assign q_nick[0] = bus.iQ1_nick;
  assign q_nick[1] = bus.iQ2_nick;

  // Same-cycle writebacks bypass the storage array.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rdy[i] = 1'b0;
      q_dt[i]  = '0;
      if (in_rng(q_nick[i])) begin
        unique case (1'b1)
          cdb_wr && (bus.iCDB_nick == q_nick[i]): begin
            q_rdy[i] = 1'b1;
            q_dt[i]  = bus.iCDB_dt;
          end
          lsb_wr && (bus.iLSB_nick == q_nick[i]): begin
            q_rdy[i] = 1'b1;
            q_dt[i]  = bus.iLSB_dt;
          end
          default: begin
            q_rdy[i] = rob[slot(q_nick[i])].ready;
            q_dt[i]  = rob[slot(q_nick[i])].dt;
          end
        endcase
      end
    end
  end

  assign bus.oQ1_rdy = q_rdy[0];
  assign bus.oQ1_dt  = q_dt[0];
  assign bus.oQ2_rdy = q_rdy[1];
  assign bus.oQ2_dt  = q_dt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      reg_en   <= 1'b0;
      reg_rd   <= '0;
      reg_dt   <= '0;
      reg_nick <= '0;
      lsb_en   <= 1'b0;
      lsb_nick <= '0;
      clr      <= 1'b0;
      if_pc    <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i] <= '0;
      end
    end else begin
      reg_en   <= cm;
      reg_rd   <= cm ? head_e.rd : '0;
      reg_dt   <= cm ? head_e.dt : '0;
      reg_nick <= cm ? head_nick : '0;
      lsb_en   <= cm && head_e.st;
      lsb_nick <= (cm && head_e.st) ? head_nick : '0;
      clr      <= mis;
      if_pc    <= mis ? redirect : '0;
      if (mis) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob[i].valid <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else if (rdy) begin
        if (cdb_wr) begin
          rob[cdb_idx].dt    <= bus.iCDB_dt;
          rob[cdb_idx].jump  <= bus.iCDB_jump;
          rob[cdb_idx].tgt   <= bus.iCDB_tgt;
          rob[cdb_idx].ready <= 1'b1;
        end
        if (lsb_wr) begin
          rob[lsb_idx].dt    <= bus.iLSB_dt;
          rob[lsb_idx].ready <= 1'b1;
        end
        if (alloc) begin
          rob[tail] <= new_e;
          tail      <= tail + IDX_W'(1);
        end
        if (cm) begin
          rob[head].valid <= 1'b0;
          rob[head].ready <= 1'b0;
          head            <= head + IDX_W'(1);
        end
        count <= count + CNT_W'(alloc) - CNT_W'(cm);
      end
    end
  end

  assign bus.oREG_en          = reg_en;
  assign bus.oREG_rd_regnm    = reg_rd;
  assign bus.oREG_rd_dt       = reg_dt;
  assign bus.oREG_rd_nick     = reg_nick;
  assign bus.oLSB_commit_en   = lsb_en;
  assign bus.oLSB_commit_nick = lsb_nick;
  assign bus.oclr             = clr;
  assign bus.oIF_pc           = if_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus a random run,
// all checked against a queue-based program-order model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  reorder_buffer_if #(.NICK_W(5), .DATA_W(32)) bus ();
  reorder_buffer #(
    .ROB_SIZE(16), .NICK_W(5), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          nick;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] dt;
    logic [31:0] tgt;
    bit          br;
    bit          pd;
    bit          st;
    bit          done;
    bit          jump;
  } ment_t;

  ment_t mq[$];
  int    mtail = 0;
  int    mdl_commits = 0;

  logic        e_full, e_nick_en;
  logic [4:0]  e_nick;
  logic        e_q1r, e_q2r;
  logic [31:0] e_q1d, e_q2d;
  logic [81:0] e_regs;

  function automatic logic [81:0] dut_regs();
    return {bus.oREG_en, bus.oREG_rd_regnm,
            bus.oREG_rd_dt, bus.oREG_rd_nick,
            bus.oLSB_commit_en, bus.oLSB_commit_nick,
            bus.oclr, bus.oIF_pc};
  endfunction

  task automatic idle();
    bus.iDP_en = 0; bus.iDP_rd_regnm = 0; bus.iDP_pc = 0;
    bus.iDP_br = 0; bus.iDP_pd = 0; bus.iDP_st = 0;
    bus.iCDB_en = 0; bus.iCDB_nick = 0; bus.iCDB_dt = 0;
    bus.iCDB_jump = 0; bus.iCDB_tgt = 0;
    bus.iLSB_en = 0; bus.iLSB_nick = 0; bus.iLSB_dt = 0;
    bus.iQ1_nick = 0; bus.iQ2_nick = 0;
    rdy = 1;
  endtask

  task automatic disp(input logic [4:0] rd,
                      input logic [31:0] pc,
                      input bit br, input bit pd,
                      input bit st);
    bus.iDP_en = 1; bus.iDP_rd_regnm = rd; bus.iDP_pc = pc;
    bus.iDP_br = br; bus.iDP_pd = pd; bus.iDP_st = st;
  endtask

  task automatic cdb(input int n, input logic [31:0] dt,
                     input bit j, input logic [31:0] tgt);
    bus.iCDB_en = 1; bus.iCDB_nick = 5'(n);
    bus.iCDB_dt = dt; bus.iCDB_jump = j; bus.iCDB_tgt = tgt;
  endtask

  function automatic void mq_query(input logic [4:0] n,
                                   output logic r,
                                   output logic [31:0] d);
    r = 0; d = 0;
    if (n == 0) return;
    foreach (mq[i]) if (mq[i].nick == int'(n)) begin
      if (bus.iCDB_en && bus.iCDB_nick == n) begin
        r = 1; d = bus.iCDB_dt;
      end else if (bus.iLSB_en && bus.iLSB_nick == n) begin
        r = 1; d = bus.iLSB_dt;
      end else if (mq[i].done) begin
        r = 1; d = mq[i].dt;
      end
    end
  endfunction

  function automatic void model_pre();
    e_full    = (mq.size() == 16);
    e_nick    = 5'(mtail + 1);
    e_nick_en = !rst && rdy && bus.iDP_en && !e_full
             && bus.iDP_rd_regnm != 0;
    mq_query(bus.iQ1_nick, e_q1r, e_q1d);
    mq_query(bus.iQ2_nick, e_q2r, e_q2d);
  endfunction

  function automatic void model_post();
    ment_t h, e;
    bit cm, mis, al;
    e_regs = '0;
    if (rst) begin
      mq.delete(); mtail = 0;
      return;
    end
    if (!rdy) return;
    al = bus.iDP_en && mq.size() < 16;
    cm = mq.size() > 0 && mq[0].done;
    mis = 0;
    if (cm) begin
      h = mq[0];
      mis = h.br && (h.jump != h.pd);
      mdl_commits++;
      e_regs = {1'b1, h.rd, h.dt, 5'(h.nick),
                h.st, h.st ? 5'(h.nick) : 5'd0, mis,
                mis ? (h.jump ? h.tgt : h.pc + 32'd4)
                    : 32'd0};
    end
    if (mis) begin
      mq.delete(); mtail = 0;
      return;
    end
    foreach (mq[i]) begin
      if (bus.iCDB_en && mq[i].nick == int'(bus.iCDB_nick)) begin
        mq[i].done = 1; mq[i].dt = bus.iCDB_dt;
        mq[i].jump = bus.iCDB_jump; mq[i].tgt = bus.iCDB_tgt;
      end
      if (bus.iLSB_en && mq[i].nick == int'(bus.iLSB_nick)) begin
        mq[i].done = 1; mq[i].dt = bus.iLSB_dt;
      end
    end
    if (cm) void'(mq.pop_front());
    if (al) begin
      e = '{nick: mtail + 1, rd: bus.iDP_rd_regnm,
            pc: bus.iDP_pc, dt: 0, tgt: 0,
            br: bus.iDP_br, pd: bus.iDP_pd,
            st: bus.iDP_st, done: 0, jump: 0};
      mq.push_back(e);
      mtail = (mtail + 1) % 16;
    end
  endfunction

  task automatic tick();
    model_post();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    disp(5'd3, 32'h8, 0, 0, 0);
    #1;
    vectors++;
    if (bus.oREG_nick_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rename got=%b want=0", bus.oREG_nick_en);
    end
    tick();
    idle(); rst = 0; model_pre(); #1;
    vectors++;
    if (dut_regs() !== 82'd0) begin
      miscompares++;
      $display("FAIL rst_regs got=%h want=0", dut_regs());
    end
    vectors++;
    if ({bus.oDP_full, bus.oDP_nick} !== {1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL rst_alloc got=%b/%0d want=0/1",
               bus.oDP_full, bus.oDP_nick);
    end
    disp(5'd4, 32'h20, 0, 0, 0); tick();
    idle(); cdb(1, 32'h9, 0, 0); tick();
    idle(); rst = 1; tick();
    rst = 0; model_pre(); #1;
    vectors++;
    if ({bus.oREG_en, bus.oDP_nick} !== {1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL rst_mid got en=%b nick=%0d want 0/1",
               bus.oREG_en, bus.oDP_nick);
    end
    tick();
    vectors++;
    if (dut_regs() !== e_regs) begin
      miscompares++;
      $display("FAIL rst_after got=%h want=%h",
               dut_regs(), e_regs);
    end
  endtask

  task automatic test_basic();
    do_reset();
    disp(5'd5, 32'h10, 0, 0, 0); model_pre(); #1;
    vectors++;
    if ({bus.oREG_nick_en, bus.oREG_nick,
         bus.oREG_nick_regnm} !== {1'b1, 5'd1, 5'd5}) begin
      miscompares++;
      $display("FAIL basic_rename got=%b/%0d/%0d want 1/1/5",
               bus.oREG_nick_en, bus.oREG_nick,
               bus.oREG_nick_regnm);
    end
    tick();
    idle(); cdb(1, 32'd7, 0, 0); tick();
    idle(); tick();
    vectors++;
    if ({bus.oREG_en, bus.oREG_rd_regnm, bus.oREG_rd_dt,
         bus.oREG_rd_nick} !== {1'b1, 5'd5, 32'd7, 5'd1}) begin
      miscompares++;
      $display("FAIL basic_commit got=%b rd=%0d dt=%0d n=%0d want 1/5/7/1",
               bus.oREG_en, bus.oREG_rd_regnm,
               bus.oREG_rd_dt, bus.oREG_rd_nick);
    end
    tick();
    vectors++;
    if (dut_regs() !== e_regs) begin
      miscompares++;
      $display("FAIL basic_drop got=%h want=%h",
               dut_regs(), e_regs);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(5'(i + 1), 32'(i * 4), 0, 0, 0); tick();
    end
    disp(5'd9, 32'h100, 0, 0, 0); model_pre(); #1;
    vectors++;
    if ({bus.oDP_full, bus.oREG_nick_en} !== {1'b1, 1'b0}
        || e_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_17th got full=%b ren=%b want 1/0",
               bus.oDP_full, bus.oREG_nick_en);
    end
    tick();
    idle(); cdb(1, 32'h55, 0, 0); tick();
    disp(5'd9, 32'h104, 0, 0, 0); model_pre(); #1;
    vectors++;
    if ({bus.oDP_full, bus.oREG_nick_en} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL full_commit_alloc got full=%b ren=%b want 1/0",
               bus.oDP_full, bus.oREG_nick_en);
    end
    tick();
    idle(); model_pre(); #1;
    vectors++;
    if (dut_regs() !== e_regs || bus.oREG_rd_nick !== 5'd1) begin
      miscompares++;
      $display("FAIL full_commit got=%h want=%h",
               dut_regs(), e_regs);
    end
    vectors++;
    if ({bus.oDP_full, bus.oDP_nick} !== {e_full, e_nick}
        || bus.oDP_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_free got=%b/%0d want=%b/%0d",
               bus.oDP_full, bus.oDP_nick, e_full, e_nick);
    end
    tick();
  endtask

  task automatic test_out_of_order();
    do_reset();
    disp(5'd1, 32'h0, 0, 0, 0); tick();
    disp(5'd2, 32'h4, 0, 0, 1); tick();
    disp(5'd3, 32'h8, 0, 0, 0); tick();
    idle(); cdb(3, 32'h33, 0, 0); tick();
    idle(); bus.iLSB_en = 1; bus.iLSB_nick = 5'd2;
    bus.iLSB_dt = 32'h22; tick();
    idle(); cdb(1, 32'h11, 0, 0); tick();
    vectors++;
    if (bus.oREG_en !== 1'b0) begin
      miscompares++;
      $display("FAIL ooo_early got=%b want=0", bus.oREG_en);
    end
    idle();
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (dut_regs() !== e_regs
          || bus.oREG_rd_nick !== 5'(k)) begin
        miscompares++;
        $display("FAIL ooo_commit%0d got=%h want=%h",
                 k, dut_regs(), e_regs);
      end
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    disp(5'd0, 32'h40, 1, 0, 0); tick();
    disp(5'd6, 32'h44, 0, 0, 0); tick();
    idle(); cdb(1, 32'h0, 1, 32'h80); tick();
    disp(5'd9, 32'h48, 0, 0, 0); tick();
    idle(); model_pre(); #1;
    vectors++;
    if ({bus.oclr, bus.oIF_pc, bus.oREG_en}
        !== {1'b1, 32'h80, 1'b1} || dut_regs() !== e_regs) begin
      miscompares++;
      $display("FAIL mp_taken got clr=%b pc=%h en=%b want 1/80/1",
               bus.oclr, bus.oIF_pc, bus.oREG_en);
    end
    vectors++;
    if ({bus.oDP_full, bus.oDP_nick} !== {1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL mp_flush got=%b/%0d want 0/1",
               bus.oDP_full, bus.oDP_nick);
    end
    disp(5'd2, 32'h100, 1, 1, 0); tick();
    disp(5'd1, 32'hFFFF_FFFC, 1, 1, 0); tick();
    idle(); cdb(1, 32'h0, 1, 32'h200); tick();
    idle(); cdb(2, 32'h1234, 0, 32'h999); tick();
    vectors++;
    if (dut_regs() !== e_regs || bus.oclr !== 1'b0) begin
      miscompares++;
      $display("FAIL mp_ok got=%h want=%h",
               dut_regs(), e_regs);
    end
    idle(); tick();
    vectors++;
    if (dut_regs() !== e_regs
        || {bus.oclr, bus.oIF_pc} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL mp_wrap got=%h want=%h",
               dut_regs(), e_regs);
    end
    tick();
    vectors++;
    if (bus.oclr !== 1'b0) begin
      miscompares++;
      $display("FAIL mp_pulse got=%b want=0", bus.oclr);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(5'(i + 1), 32'(i * 4), 0, 0, 0); tick();
    end
    idle(); cdb(2, 32'hAB, 0, 0);
    bus.iLSB_en = 1; bus.iLSB_nick = 5'd1; bus.iLSB_dt = 32'hCD;
    bus.iQ1_nick = 5'd2; bus.iQ2_nick = 5'd1;
    model_pre(); #1;
    vectors++;
    if ({bus.oQ1_rdy, bus.oQ1_dt, bus.oQ2_rdy, bus.oQ2_dt}
        !== {1'b1, 32'hAB, 1'b1, 32'hCD}) begin
      miscompares++;
      $display("FAIL byp_same got=%b/%h %b/%h want 1/ab 1/cd",
               bus.oQ1_rdy, bus.oQ1_dt, bus.oQ2_rdy, bus.oQ2_dt);
    end
    tick();
    idle(); bus.iQ1_nick = 5'd2; bus.iQ2_nick = 5'd3;
    model_pre(); #1;
    vectors++;
    if ({bus.oQ1_rdy, bus.oQ1_dt, bus.oQ2_rdy}
        !== {e_q1r, e_q1d, e_q2r} || e_q1r !== 1'b1) begin
      miscompares++;
      $display("FAIL byp_stored got=%b/%h %b want %b/%h %b",
               bus.oQ1_rdy, bus.oQ1_dt, bus.oQ2_rdy,
               e_q1r, e_q1d, e_q2r);
    end
    bus.iQ1_nick = 5'd0; bus.iQ2_nick = 5'd17; #1;
    vectors++;
    if ({bus.oQ1_rdy, bus.oQ2_rdy} !== 2'b00) begin
      miscompares++;
      $display("FAIL byp_nick0 got=%b%b want 00",
               bus.oQ1_rdy, bus.oQ2_rdy);
    end
    tick();
  endtask

  task automatic test_wrap_random();
    int pend[$];
    int dut_commits = 0;
    int a, b;
    do_reset();
    mdl_commits = 0;
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom % 4) != 0;
      if ($urandom % 3 != 0) begin
        a = $urandom % 4;
        disp(5'($urandom), $urandom & 32'hFFFF_FFFC,
             a == 0, 1'($urandom), a == 1);
      end
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(i);
      if (pend.size() > 0 && $urandom % 2 == 0) begin
        a = pend[$urandom % pend.size()];
        cdb(mq[a].nick, $urandom,
            ($urandom % 16 == 0) ? !mq[a].pd : mq[a].pd,
            $urandom);
        pend = pend.find(x) with (x != a);
      end
      if (pend.size() > 0 && $urandom % 2 == 0) begin
        b = pend[$urandom % pend.size()];
        bus.iLSB_en = 1; bus.iLSB_nick = 5'(mq[b].nick);
        bus.iLSB_dt = $urandom;
      end
      bus.iQ1_nick = 5'($urandom % 18);
      bus.iQ2_nick = 5'($urandom % 18);
      model_pre(); #1;
      vectors++;
      if ({bus.oDP_full, bus.oDP_nick, bus.oREG_nick_en}
          !== {e_full, e_nick, e_nick_en}
          || (e_nick_en && bus.oREG_nick_regnm
              !== bus.iDP_rd_regnm)) begin
        miscompares++;
        $display("FAIL rnd_alloc c=%0d got=%b/%0d/%b want=%b/%0d/%b",
                 c, bus.oDP_full, bus.oDP_nick, bus.oREG_nick_en,
                 e_full, e_nick, e_nick_en);
      end
      vectors++;
      if ({bus.oQ1_rdy, bus.oQ2_rdy} !== {e_q1r, e_q2r}
          || (e_q1r && bus.oQ1_dt !== e_q1d)
          || (e_q2r && bus.oQ2_dt !== e_q2d)) begin
        miscompares++;
        $display("FAIL rnd_query c=%0d got=%b/%h %b/%h want=%b/%h %b/%h",
                 c, bus.oQ1_rdy, bus.oQ1_dt, bus.oQ2_rdy,
                 bus.oQ2_dt, e_q1r, e_q1d, e_q2r, e_q2d);
      end
      tick();
      if (bus.oREG_en === 1'b1) dut_commits++;
      vectors++;
      if (dut_regs() !== e_regs) begin
        miscompares++;
        $display("FAIL rnd_commit c=%0d got=%h want=%h",
                 c, dut_regs(), e_regs);
      end
    end
    vectors++;
    if (dut_commits !== mdl_commits || mdl_commits < 40) begin
      miscompares++;
      $display("FAIL rnd_count got=%0d want=%0d (>=40)",
               dut_commits, mdl_commits);
    end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_mispredict();
    test_bypass();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
